// File: rtl/i2c_target_regs.sv
// I2C target with a 256x8 register file, auto-incrementing pointer and a host load port.
// SCL/SDA are oversampled on the system clock; SDA is driven open-drain via sda_oe.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h68,
    parameter logic [7:0] WHO_AM_I = 8'h71
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic       busy,
    output logic       wr_strobe,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck, StRdata, StRdataAck
    } state_t;

    state_t     state;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_hist, sda_hist;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic       rw;
    logic       rd_ack;
    logic [7:0] regs [256];

    logic       scl, sda, scl_rise, scl_fall, start_cond, stop_cond;
    logic [7:0] byte_in, rd_byte;
    logic       wr_commit;

    assign scl        = scl_sync[1];
    assign sda        = sda_sync[1];
    assign scl_rise   = scl & ~scl_hist;
    assign scl_fall   = ~scl & scl_hist;
    assign start_cond = scl & scl_hist & sda_hist & ~sda;
    assign stop_cond  = scl & scl_hist & ~sda_hist & sda;
    assign byte_in    = {shift[6:0], sda};
    assign rd_byte    = regs[ptr];
    // sda_oe high in WDATA_ACK means the ACK bit is in progress; this fall ends it
    assign wr_commit  = (state == StWdataAck) & ~start_cond & ~stop_cond & scl_fall & sda_oe;

    // Two-flop synchronizers plus one history flop for edge detection
    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync <= 2'b00;
            sda_sync <= 2'b00;
            scl_hist <= 1'b0;
            sda_hist <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_hist <= scl_sync[1];
            sda_hist <= sda_sync[1];
        end
    end

    // Register file: I2C write beats a host load to the same address
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 256; i++) begin
                regs[i[7:0]] <= (i[7:0] == 8'h75) ? WHO_AM_I : 8'h00;
            end
        end else begin
            if (load_en && !(wr_commit && (load_addr == ptr))) begin
                regs[load_addr] <= load_data;
            end
            if (wr_commit) begin
                regs[ptr] <= shift;
            end
        end
    end

    // Protocol FSM with registered bus and host-side outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= StIdle;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            ptr       <= 8'h00;
            rw        <= 1'b0;
            rd_ack    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
        end else begin
            wr_strobe <= 1'b0;
            if (start_cond) begin
                state   <= StAddr;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
            end else if (stop_cond) begin
                state  <= StIdle;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    StAddr: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state <= StAddrAck;
                                busy  <= 1'b1;
                                rw    <= byte_in[0];
                            end else begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    StAddrAck: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else if (rw) begin
                            shift   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 3'd0;
                            state   <= StRdata;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= StPtr;
                        end
                    end
                    StPtr: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            ptr   <= byte_in;
                            state <= StPtrAck;
                        end
                    end
                    StPtrAck: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= StWdata;
                        end
                    end
                    StWdata: if (scl_rise) begin
                        shift   <= byte_in;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= StWdataAck;
                        end
                    end
                    StWdataAck: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= shift;
                            ptr       <= ptr + 8'd1;
                            sda_oe    <= 1'b0;
                            state     <= StWdata;
                        end
                    end
                    StRdata: if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            rd_ack  <= 1'b0;
                            state   <= StRdataAck;
                        end else begin
                            shift   <= {shift[6:0], 1'b0};
                            sda_oe  <= ~shift[6];
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    StRdataAck: begin
                        if (scl_rise) begin
                            ptr <= ptr + 8'd1;
                            if (sda) begin
                                state <= StIdle;
                                busy  <= 1'b0;
                            end else begin
                                rd_ack <= 1'b1;
                            end
                        end else if (scl_fall && rd_ack) begin
                            // ptr already advanced on the ACK rise
                            shift   <= rd_byte;
                            sda_oe  <= ~rd_byte[7];
                            bit_cnt <= 3'd0;
                            rd_ack  <= 1'b0;
                            state   <= StRdata;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
